// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants.
// Used by the layer-2 window loader slice.
package cnn_pkg;
  localparam int BYTE_W    = 8;
  localparam int OFM_DEPTH = 172;
  localparam int WIN_LINES = 2;

  typedef logic [BYTE_W-1:0] pixel_t;
endpackage

// File: rtl/layer2_window_loader_if.sv
// OFM memory read port between the window loader
// and the layer-1 output feature map memory.
interface layer2_window_loader_if
  import cnn_pkg::*;
#(
  parameter int KERNEL_COUNT = 4,
  parameter int ADDR_W       = 8
);
  logic                             mem_rd_en;
  logic [ADDR_W-1:0]                mem_rd_addr;
  pixel_t [0:KERNEL_COUNT-1][0:1]   mem_rd_data;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data
  );
endinterface

// File: rtl/window_pos_counter.sv
// 2-D row/column wrap counter for window positions.
// last flags the final position of the feature map.
module window_pos_counter #(
  parameter int ROWS  = 12,
  parameter int COLS  = 13,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  logic row_end;
  logic col_end;

  assign col_end = (col == COL_W'(COLS - 1));
  assign row_end = (row == ROW_W'(ROWS - 1));
  assign last    = row_end && col_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/layer2_window_loader.sv
// Walks the layer-1 OFM and assembles one 2x2 window
// per kernel channel for cnn_layer2.
module layer2_window_loader
  import cnn_pkg::*;
#(
  parameter int KERNEL_COUNT = 4,
  parameter int ROW_STRIDE   = 13,
  parameter int POS_COLS     = 13,
  parameter int POS_ROWS     = 12,
  parameter int ADDR_W       = $clog2(OFM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           line_en,
  input  logic                           pos_en,
  layer2_window_loader_if.master         mem,
  output pixel_t [0:KERNEL_COUNT-1][0:3] window_out,
  output logic                           window_ld_done,
  output logic                           cout_addr_generator
);
  localparam int ROW_W = $clog2(POS_ROWS);
  localparam int COL_W = $clog2(POS_COLS);

  logic [ROW_W-1:0]  pos_row;
  logic [COL_W-1:0]  pos_col;
  logic              pos_last;
  logic [1:0]        line;
  logic              cap_pending;
  logic              cap_line;
  logic              issue;
  logic [ADDR_W-1:0] row_sum;

  window_pos_counter #(
    .ROWS (POS_ROWS),
    .COLS (POS_COLS)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (pos_en),
    .row  (pos_row),
    .col  (pos_col),
    .last (pos_last)
  );

  // start and pos_en both pre-empt a line fetch
  assign issue = line_en && !pos_en && !start
              && (line != 2'(WIN_LINES));

  assign row_sum = ADDR_W'(pos_row) + ADDR_W'(line);

  assign mem.mem_rd_en   = issue;
  assign mem.mem_rd_addr = row_sum * ADDR_W'(ROW_STRIDE)
                         + ADDR_W'(pos_col);

  assign cout_addr_generator = pos_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line           <= '0;
      cap_pending    <= 1'b0;
      cap_line       <= 1'b0;
      window_out     <= '0;
      window_ld_done <= 1'b0;
    end else if (start) begin
      line           <= '0;
      cap_pending    <= 1'b0;
      cap_line       <= 1'b0;
      window_out     <= '0;
      window_ld_done <= 1'b0;
    end else begin
      window_ld_done <= cap_pending && cap_line;
      if (cap_pending) begin
        for (int k = 0; k < KERNEL_COUNT; k++) begin
          if (cap_line) begin
            window_out[k][2] <= mem.mem_rd_data[k][0];
            window_out[k][3] <= mem.mem_rd_data[k][1];
          end else begin
            window_out[k][0] <= mem.mem_rd_data[k][0];
            window_out[k][1] <= mem.mem_rd_data[k][1];
          end
        end
      end
      cap_pending <= issue;
      if (issue) begin
        cap_line <= line[0];
      end
      if (pos_en) begin
        line <= '0;
      end else if (issue) begin
        line <= line + 2'd1;
      end
    end
  end
endmodule
